// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// With UART_RX_MAJORITY_EN defined the decision point moves one cycle later.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_W_DEF     = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sample_mid(input int os);
    return os / 2;
  endfunction

  // Cycle within a bit at which the bit value is final.
  function automatic int decision_pt(input int os);
`ifdef UART_RX_MAJORITY_EN
    return os / 2 + 1;
`else
    return os / 2;
`endif
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Pad-side line, frame configuration and system-side result of the UART receiver.
// slave is the receiver's view, master the driver/consumer's view.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              RX_IN;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic [DATA_W-1:0] P_DATA;
  logic              DATA_VALID;
  logic              PAR_ERR;
  logic              STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-timing counter and sample decision; combinational pulses, no backpressure.
// UART_RX_MAJORITY_EN selects 3-sample majority (decision one cycle after mid-bit).
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
)
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic rx_s,
  output logic sample_val,
  output logic sample_vld,
  output logic bit_end
);

  localparam int            EW   = cnt_w(OVERSAMPLE);
  localparam logic [EW-1:0] LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] DEC  = EW'(decision_pt(OVERSAMPLE));

  logic [EW-1:0] edge_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      edge_cnt <= '0;
    end else if (en) begin
      edge_cnt <= (edge_cnt == LAST) ? '0 : edge_cnt + 1'b1;
    end
  end

  assign bit_end    = en && (edge_cnt == LAST);
  assign sample_vld = en && (edge_cnt == DEC);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] MID = EW'(sample_mid(OVERSAMPLE));

  logic s_early;
  logic s_mid;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (en) begin
      if (edge_cnt == MID - 1'b1) s_early <= rx_s;
      if (edge_cnt == MID)        s_mid   <= rx_s;
    end
  end

  // Third vote is the live sample at MID+1, the decision cycle.
  assign sample_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
  assign sample_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: sync, start validation, LSB-first data, optional parity, stop check.
// Strobes one cycle after the stop decision; no backpressure. Option: UART_RX_MAJORITY_EN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_W     = DATA_W_DEF
)
(
  input  logic CLK,
  input  logic RST,
  uart_rx_if.slave bus
);

  localparam int            BW       = cnt_w(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              sync1;
  logic              rx_s;
  state_t            state, state_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] sr, sr_n;
  logic              par_en_q, par_en_n;
  logic              par_typ_q, par_typ_n;
  logic              par_fail, par_fail_n;
  logic [DATA_W-1:0] p_data, p_data_n;
  logic              data_valid, data_valid_n;
  logic              par_err, par_err_n;
  logic              stp_err, stp_err_n;
  logic              clr;
  logic              sample_val;
  logic              sample_vld;
  logic              bit_end;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.RX_IN;
      rx_s  <= sync1;
    end
  end

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .clr        (clr),
    .en         (state != IDLE),
    .rx_s       (rx_s),
    .sample_val (sample_val),
    .sample_vld (sample_vld),
    .bit_end    (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      sr         <= sr_n;
      par_en_q   <= par_en_n;
      par_typ_q  <= par_typ_n;
      par_fail   <= par_fail_n;
      p_data     <= p_data_n;
      data_valid <= data_valid_n;
      par_err    <= par_err_n;
      stp_err    <= stp_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    sr_n         = sr;
    par_en_n     = par_en_q;
    par_typ_n    = par_typ_q;
    par_fail_n   = par_fail;
    p_data_n     = p_data;
    data_valid_n = 1'b0;
    par_err_n    = 1'b0;
    stp_err_n    = 1'b0;
    clr          = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n    = START;
          clr        = 1'b1;
          bit_cnt_n  = '0;
          par_fail_n = 1'b0;
          par_en_n   = bus.PAR_EN;
          par_typ_n  = bus.PAR_TYP;
        end
      end
      START: begin
        if (sample_vld && sample_val) begin
          state_n = IDLE;
        end else if (bit_end) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (sample_vld) sr_n[bit_cnt] = sample_val;
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample_vld && (sample_val != ((^sr) ^ par_typ_q))) par_fail_n = 1'b1;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (sample_vld) begin
          state_n   = IDLE;
          stp_err_n = !sample_val;
          par_err_n = par_fail;
          if (sample_val && !par_fail) begin
            data_valid_n = 1'b1;
            p_data_n     = sr;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = data_valid;
  assign bus.PAR_ERR    = par_err;
  assign bus.STP_ERR    = stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded random/directed frames against a timing/value model of the receiver.
module tb_uart_rx;

  localparam int OS = 8;
  localparam int DW = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int S_DEC = OS / 2 + 1;
  localparam bit MAJ   = 1'b1;
`else
  localparam int S_DEC = OS / 2;
  localparam bit MAJ   = 1'b0;
`endif

  typedef struct {
    int            cyc;
    bit            dv;
    bit            pe;
    bit            se;
    logic [DW-1:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   strobe_cnt = 0;
  exp_t q[$];
  logic [DW-1:0] last_good;

  uart_rx_if #(.DATA_W(DW)) bus();

  uart_rx #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: every strobe cycle must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b0 && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
      strobe_cnt++;
      if (q.size() == 0) begin
        check("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("strobe_cycle", 64'(cyc), 64'(e.cyc));
        check("data_valid", 64'(bus.DATA_VALID), 64'(e.dv));
        check("par_err", 64'(bus.PAR_ERR), 64'(e.pe));
        check("stp_err", 64'(bus.STP_ERR), 64'(e.se));
        check("p_data", 64'(bus.P_DATA), 64'(e.data));
      end
    end
  end

  task automatic drive_bit(input logic v, input bit spike);
    bus.RX_IN = v;
    if (spike) begin
      // Inverted for exactly the cycle the centre sample is taken.
      wait_cyc(OS / 2 + 1);
      bus.RX_IN = ~v;
      wait_cyc(1);
      bus.RX_IN = v;
      wait_cyc(OS - OS / 2 - 2);
    end else begin
      wait_cyc(OS);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                            input bit par_bad, input bit stop_bad, input int abort_bit,
                            input bit spike, input int gap, input bit scramble);
    int   k;
    exp_t e;
    logic pbit;
    k    = cyc;
    pbit = (^d) ^ pt ^ par_bad;
    if (abort_bit < 0) begin
      // Start edge seen after 2 sync cycles, START entered the cycle after.
      e.cyc = k + 3 + (1 + DW + (pe ? 1 : 0)) * OS + S_DEC + 1;
      e.pe  = pe && par_bad;
      e.se  = stop_bad;
      e.dv  = !e.pe && !e.se;
      if (e.dv) last_good = d;
      e.data = last_good;
      q.push_back(e);
    end
    bus.PAR_EN  = pe;
    bus.PAR_TYP = pt;
    drive_bit(1'b0, 1'b0);
    if (scramble) begin
      bus.PAR_EN  = 1'($urandom);
      bus.PAR_TYP = 1'($urandom);
    end
    for (int i = 0; i < DW; i++) begin
      if (i == abort_bit) begin
        bus.RX_IN = d[i];
        wait_cyc(OS / 2);
        bus.RX_IN = 1'b1;
        RST = 1'b1;
        wait_cyc(1);
        RST = 1'b0;
        return;
      end
      drive_bit(d[i], spike);
    end
    if (pe) drive_bit(pbit, spike);
    drive_bit(!stop_bad, 1'b0);
    bus.RX_IN = 1'b1;
    if (gap > 0) wait_cyc(gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 2000) begin
      wait_cyc(1);
      t++;
    end
    check("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int            s0;
    logic [DW-1:0] d;
    bit            pe, pt, pb, sb, sp;
    int            gap;

    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    RST         = 1'b1;
    last_good   = '0;
    wait_cyc(4);
    check("reset_p_data", 64'(bus.P_DATA), 64'd0);
    check("reset_data_valid", 64'(bus.DATA_VALID), 64'd0);
    check("reset_par_err", 64'(bus.PAR_ERR), 64'd0);
    check("reset_stp_err", 64'(bus.STP_ERR), 64'd0);
    RST = 1'b0;
    wait_cyc(2 * OS);

    send_frame(8'hA5, 1, 0, 0, 0, -1, 0, 2 * OS, 0);
    send_frame(8'hA5, 1, 0, 1, 0, -1, 0, 2 * OS, 0);
    send_frame(8'h01, 1, 1, 0, 0, -1, 0, 2 * OS, 0);
    send_frame(8'h3C, 0, 0, 0, 1, -1, 0, 2 * OS, 0);

    s0 = strobe_cnt;
    bus.RX_IN = 1'b0;
    wait_cyc(2);
    bus.RX_IN = 1'b1;
    wait_cyc(3 * OS);
    check("glitch_no_strobe", 64'(strobe_cnt - s0), 64'd0);
    send_frame(8'h55, 0, 0, 0, 0, -1, 0, 2 * OS, 0);

    send_frame(8'h00, 0, 0, 0, 0, -1, 0, 0, 0);
    send_frame(8'hFF, 0, 0, 0, 0, -1, 0, 2 * OS, 0);
    drain();

    s0 = strobe_cnt;
    send_frame(8'h5A, 0, 0, 0, 0, 4, 0, 0, 0);
    check("abort_p_data", 64'(bus.P_DATA), 64'd0);
    check("abort_data_valid", 64'(bus.DATA_VALID), 64'd0);
    check("abort_par_err", 64'(bus.PAR_ERR), 64'd0);
    check("abort_stp_err", 64'(bus.STP_ERR), 64'd0);
    last_good = '0;
    wait_cyc(3 * OS);
    check("abort_no_strobe", 64'(strobe_cnt - s0), 64'd0);
    send_frame(8'h81, 0, 0, 0, 0, -1, 0, 2 * OS, 0);
    if (MAJ) begin
      send_frame(8'h81, 0, 0, 0, 0, -1, 1, 2 * OS, 0);
      send_frame(8'hC3, 1, 1, 0, 0, -1, 1, 2 * OS, 0);
    end

    for (int n = 0; n < 40; n++) begin
      d   = DW'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      pb  = ($urandom_range(0, 4) == 0);
      sb  = ($urandom_range(0, 5) == 0);
      sp  = MAJ && ($urandom_range(0, 1) == 1);
      gap = sb ? 2 * OS : (($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3 * OS)));
      send_frame(d, pe, pt, pb, sb, -1, sp, gap, 1);
    end

    drain();
    wait_cyc(2 * OS);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
